sc_game_fsm: RTL and testbench
==============================

# sc_game_fsm

Game-flow controller for Frogger, directly downstream of the win comparator. It consumes the comparator's active-low win flag and the lane collision flag. It sequences the game through idle, play, level-up, life-lost and game-over phases, and tracks the current level and remaining lives. It emits a one-cycle clear pulse that re-spawns the frog, plus a speed-select level bus for the lane shifters.

## Interface
- LIVES_INIT, 3: lives loaded on game start (1..7)
- LEVEL_WIDTH, 3: width of level bus
- LEVEL_MAX, 7: last level; winning here ends the game as a victory
- HOLD_TICKS, 8: tick count spent in each transient state (1..255)

- SC_GAMEFSM_CLOCK_50  in  1  system clock
- SC_GAMEFSM_RESET_InHigh  in  1  synchronous reset, active-high
- SC_GAMEFSM_tick_In  in  1  one-cycle game-step strobe (frame rate)
- SC_GAMEFSM_start_InLow  in  1  start button, active-low, level-sensitive
- SC_GAMEFSM_win_InLow  in  1  win flag from comparator, active-low
- SC_GAMEFSM_collision_InLow  in  1  frog/car collision, active-low
- SC_GAMEFSM_pause_InLow  in  1  pause button, active-low (used only with macro)
- SC_GAMEFSM_level_Out  out  LEVEL_WIDTH  current level, 0-based
- SC_GAMEFSM_lives_Out  out  3  remaining lives
- SC_GAMEFSM_clear_OutHigh  out  1  one-cycle frog re-spawn pulse
- SC_GAMEFSM_run_OutHigh  out  1  high while lanes/frog may move
- SC_GAMEFSM_state_Out  out  3  state code, for display
- SC_GAMEFSM_victory_OutHigh  out  1  game ended by clearing LEVEL_MAX

## Operation
- States and codes:
  - IDLE=0
  - PLAY=1
  - LEVELUP=2
  - DIED=3
  - GAMEOVER=4
  - PAUSED=5 (macro only)
- Reset values:
  - state=IDLE, level=0, lives=0
  - clear=0, run=0, victory=0
  - hold counter=0
- IDLE: start_InLow==0 → PLAY.
  - Entry into PLAY from IDLE: level=0, lives=LIVES_INIT, victory=0.
  - clear pulses in the cycle the state becomes PLAY.
- PLAY: run=1. Evaluated every cycle, not only on tick.
  - win_InLow==0 and level<LEVEL_MAX → LEVELUP; level increments on entry.
  - win_InLow==0 and level==LEVEL_MAX → GAMEOVER, victory=1; level is not incremented.
  - collision_InLow==0 (no win) → DIED; lives decrements on entry.
  - Win and collision in the same cycle: win has priority.
- LEVELUP / DIED:
  - run=0; hold counter clears on entry.
  - Counter increments per tick; leaves after HOLD_TICKS ticks.
  - LEVELUP → PLAY with clear pulse.
  - DIED with lives>0 → PLAY with clear pulse.
  - DIED with lives==0 → GAMEOVER, victory=0.
- GAMEOVER:
  - run=0; level, lives and victory hold their values.
  - start_InLow==0 → wait for start_InLow==1 (release), then → IDLE.
  - Release-before-restart is tracked by an internal armed flag, set on entry only once start is high.
- Arithmetic: lives never underflows, because decrement only occurs from PLAY with lives≥1. level saturates at LEVEL_MAX.
- Inputs are assumed already synchronous to SC_GAMEFSM_CLOCK_50.

## Timing
- State register, counters and outputs are all registered.
- Outputs change the cycle after the triggering input is sampled.
- clear_OutHigh is exactly one cycle wide per PLAY entry.
- Transient states last HOLD_TICKS tick strobes; cycle count depends on tick spacing.
  - A tick coincident with entry does not count.
- Reset asserted in any state → IDLE at the next edge, all outputs at reset values. Reset dominates all inputs.
- win/collision ignored outside PLAY (win stays low while the frog sits on the goal row until clear).

## Configuration
- Macro: SC_GAMEFSM_PAUSE_EN.
- Defined:
  - PLAY with pause_InLow==0 and no win/collision → PAUSED; run=0, counters frozen.
  - PAUSED with pause_InLow==1 → PLAY without clear pulse.
  - Win/collision take priority over pause.
- Undefined:
  - pause_InLow ignored; PAUSED state and code 5 never occur.
  - state_Out remains 3 bits.

## Structure
- Shared package (sc_game_pkg):
  - state encoding localparams
  - lives width (3)
  - default LIVES_INIT / LEVEL_MAX / HOLD_TICKS
- Sub-module sc_tick_holdcounter (8-bit tick counter):
  - inputs: clear, enable
  - output: done when count == HOLD_TICKS
  - used for LEVELUP and DIED.

## Test plan
- Reset, start low one cycle → PLAY next cycle, level=0, lives=3, clear high exactly one cycle, run=1.
- In PLAY, win_InLow low one cycle → LEVELUP, level=1, run=0.
  - After 8 ticks → PLAY, clear pulse.
- Three collisions with hold completion → lives 2,1,0, then GAMEOVER with victory=0.
  - Start held low on entry → remains GAMEOVER until released and pressed again, then IDLE.
- Force level=7 via seven wins; eighth win → GAMEOVER, victory=1, level stays 7.
- Win and collision low in the same PLAY cycle → LEVELUP, lives unchanged.
- Reset asserted mid-DIED hold → IDLE, lives=0, level=0 next cycle.
- With SC_GAMEFSM_PAUSE_EN: pause low in PLAY → state=5, run=0; release → PLAY with no clear pulse.

Source files
------------

// File: rtl/sc_game_pkg.sv
// Shared definitions for the Frogger game-flow controller: state codes,
// lives width and default timing/limit parameters.
package sc_game_pkg;

    localparam logic [2:0] STATE_IDLE     = 3'd0;
    localparam logic [2:0] STATE_PLAY     = 3'd1;
    localparam logic [2:0] STATE_LEVELUP  = 3'd2;
    localparam logic [2:0] STATE_DIED     = 3'd3;
    localparam logic [2:0] STATE_GAMEOVER = 3'd4;
    localparam logic [2:0] STATE_PAUSED   = 3'd5;

    localparam int LIVES_WIDTH    = 3;
    localparam int HOLD_WIDTH     = 8;
    localparam int LIVES_INIT_DEF = 3;
    localparam int LEVEL_MAX_DEF  = 7;
    localparam int HOLD_TICKS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = STATE_IDLE,
        ST_PLAY     = STATE_PLAY,
        ST_LEVELUP  = STATE_LEVELUP,
        ST_DIED     = STATE_DIED,
        ST_GAMEOVER = STATE_GAMEOVER,
        ST_PAUSED   = STATE_PAUSED
    } game_state_t;

    function automatic logic is_hold_state(input game_state_t s);
        return (s == ST_LEVELUP) || (s == ST_DIED);
    endfunction

endpackage

// File: rtl/sc_tick_holdcounter.sv
// Counts tick strobes while enabled; done stays high once HOLD_TICKS ticks
// have been seen, until the next clear.
module sc_tick_holdcounter
    import sc_game_pkg::*;
#(
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_L = HOLD_WIDTH'(HOLD_TICKS);

    logic [HOLD_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (enable && !done) begin
            count_reg <= count_reg + HOLD_WIDTH'(1);
        end
    end

    assign done = (count_reg == HOLD_L);

endmodule

// File: rtl/sc_game_fsm.sv
// Frogger game-flow controller: idle/play/level-up/died/game-over sequencing,
// level and lives tracking. Optional pause state enabled by SC_GAMEFSM_PAUSE_EN.
module sc_game_fsm
    import sc_game_pkg::*;
#(
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int LEVEL_WIDTH = 3,
    parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF
) (
    input  logic                   SC_GAMEFSM_CLOCK_50,
    input  logic                   SC_GAMEFSM_RESET_InHigh,
    input  logic                   SC_GAMEFSM_tick_In,
    input  logic                   SC_GAMEFSM_start_InLow,
    input  logic                   SC_GAMEFSM_win_InLow,
    input  logic                   SC_GAMEFSM_collision_InLow,
    input  logic                   SC_GAMEFSM_pause_InLow,
    output logic [LEVEL_WIDTH-1:0] SC_GAMEFSM_level_Out,
    output logic [LIVES_WIDTH-1:0] SC_GAMEFSM_lives_Out,
    output logic                   SC_GAMEFSM_clear_OutHigh,
    output logic                   SC_GAMEFSM_run_OutHigh,
    output logic [2:0]             SC_GAMEFSM_state_Out,
    output logic                   SC_GAMEFSM_victory_OutHigh
);

    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX_L  = LEVEL_WIDTH'(LEVEL_MAX);
    localparam logic [LIVES_WIDTH-1:0] LIVES_INIT_L = LIVES_WIDTH'(LIVES_INIT);

    logic clk;
    logic srst;
    assign clk  = SC_GAMEFSM_CLOCK_50;
    assign srst = SC_GAMEFSM_RESET_InHigh;

    game_state_t            state_reg,   state_next;
    logic [LEVEL_WIDTH-1:0] level_reg,   level_next;
    logic [LIVES_WIDTH-1:0] lives_reg,   lives_next;
    logic                   victory_reg, victory_next;
    logic                   clear_reg,   clear_next;
    logic                   run_reg,     run_next;
    logic                   armed_reg,   armed_next;
    logic                   pressed_reg, pressed_next;
    logic                   hold_done;

`ifndef SC_GAMEFSM_PAUSE_EN
    logic unused_pause;
    assign unused_pause = SC_GAMEFSM_pause_InLow;
`endif

    // Counter is held cleared outside the hold states, so the tick sampled on
    // the entry edge is never counted.
    sc_tick_holdcounter #(
        .HOLD_TICKS(HOLD_TICKS)
    ) u_hold (
        .clk    (clk),
        .srst   (srst),
        .clear  (!is_hold_state(state_reg)),
        .enable (SC_GAMEFSM_tick_In),
        .done   (hold_done)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= ST_IDLE;
            level_reg   <= '0;
            lives_reg   <= '0;
            victory_reg <= 1'b0;
            clear_reg   <= 1'b0;
            run_reg     <= 1'b0;
            armed_reg   <= 1'b0;
            pressed_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            level_reg   <= level_next;
            lives_reg   <= lives_next;
            victory_reg <= victory_next;
            clear_reg   <= clear_next;
            run_reg     <= run_next;
            armed_reg   <= armed_next;
            pressed_reg <= pressed_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        level_next   = level_reg;
        lives_next   = lives_reg;
        victory_next = victory_reg;
        clear_next   = 1'b0;
        armed_next   = armed_reg;
        pressed_next = pressed_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!SC_GAMEFSM_start_InLow) begin
                    state_next   = ST_PLAY;
                    level_next   = '0;
                    lives_next   = LIVES_INIT_L;
                    victory_next = 1'b0;
                    clear_next   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!SC_GAMEFSM_win_InLow) begin
                    if (level_reg < LEVEL_MAX_L) begin
                        state_next = ST_LEVELUP;
                        level_next = level_reg + LEVEL_WIDTH'(1);
                    end else begin
                        state_next   = ST_GAMEOVER;
                        victory_next = 1'b1;
                    end
                end else if (!SC_GAMEFSM_collision_InLow) begin
                    state_next = ST_DIED;
                    lives_next = (lives_reg != '0) ? lives_reg - LIVES_WIDTH'(1) : '0;
`ifdef SC_GAMEFSM_PAUSE_EN
                end else if (!SC_GAMEFSM_pause_InLow) begin
                    state_next = ST_PAUSED;
`endif
                end
            end
            ST_LEVELUP: begin
                if (hold_done) begin
                    state_next = ST_PLAY;
                    clear_next = 1'b1;
                end
            end
            ST_DIED: begin
                if (hold_done) begin
                    if (lives_reg != '0) begin
                        state_next = ST_PLAY;
                        clear_next = 1'b1;
                    end else begin
                        state_next   = ST_GAMEOVER;
                        victory_next = 1'b0;
                    end
                end
            end
            ST_GAMEOVER: begin
                // Restart needs release, press, release so a held button
                // cannot bounce straight through IDLE into a new game.
                if (!armed_reg) begin
                    armed_next = SC_GAMEFSM_start_InLow;
                end else if (!pressed_reg) begin
                    pressed_next = !SC_GAMEFSM_start_InLow;
                end else if (SC_GAMEFSM_start_InLow) begin
                    state_next   = ST_IDLE;
                    armed_next   = 1'b0;
                    pressed_next = 1'b0;
                end
            end
`ifdef SC_GAMEFSM_PAUSE_EN
            ST_PAUSED: begin
                if (SC_GAMEFSM_pause_InLow) begin
                    state_next = ST_PLAY;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        run_next = (state_next == ST_PLAY);
    end

    assign SC_GAMEFSM_level_Out       = level_reg;
    assign SC_GAMEFSM_lives_Out       = lives_reg;
    assign SC_GAMEFSM_clear_OutHigh   = clear_reg;
    assign SC_GAMEFSM_run_OutHigh     = run_reg;
    assign SC_GAMEFSM_state_Out       = state_reg;
    assign SC_GAMEFSM_victory_OutHigh = victory_reg;

endmodule

// File: tb/tb_sc_game_fsm.sv
// Self-checking bench for sc_game_fsm: directed vector table, hand-written
// game sequences and randomized play against a behavioural game model.
module tb_sc_game_fsm;

    localparam int LIVES_INIT  = 3;
    localparam int LEVEL_WIDTH = 3;
    localparam int LEVEL_MAX   = 7;
    localparam int HOLD_TICKS  = 8;
`ifdef SC_GAMEFSM_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, tick = 1'b0, start_n = 1'b1, win_n = 1'b1, coll_n = 1'b1, pause_n = 1'b1;
    logic [LEVEL_WIDTH-1:0] level;
    logic [2:0] lives, state;
    logic clear, run, victory;

    sc_game_fsm #(
        .LIVES_INIT(LIVES_INIT), .LEVEL_WIDTH(LEVEL_WIDTH),
        .LEVEL_MAX(LEVEL_MAX), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .SC_GAMEFSM_CLOCK_50        (clk),
        .SC_GAMEFSM_RESET_InHigh    (rst),
        .SC_GAMEFSM_tick_In         (tick),
        .SC_GAMEFSM_start_InLow     (start_n),
        .SC_GAMEFSM_win_InLow       (win_n),
        .SC_GAMEFSM_collision_InLow (coll_n),
        .SC_GAMEFSM_pause_InLow     (pause_n),
        .SC_GAMEFSM_level_Out       (level),
        .SC_GAMEFSM_lives_Out       (lives),
        .SC_GAMEFSM_clear_OutHigh   (clear),
        .SC_GAMEFSM_run_OutHigh     (run),
        .SC_GAMEFSM_state_Out       (state),
        .SC_GAMEFSM_victory_OutHigh (victory)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Game model: phase codes 0 idle, 1 play, 2 level-up, 3 died, 4 over, 5 paused
    int m_state = 0, m_level = 0, m_lives = 0, m_ticks = 0, m_go = 0;
    int m_clear = 0, m_run = 0, m_vic = 0;

    typedef struct {
        bit r, t, s, w, c;
        int st, lv, li, cl, ru, vi;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit r, bit t, bit s, bit w, bit c,
                                int st, int lv, int li, int cl, int ru, int vi);
        vec_t v;
        v.r = r; v.t = t; v.s = s; v.w = w; v.c = c;
        v.st = st; v.lv = lv; v.li = li; v.cl = cl; v.ru = ru; v.vi = vi;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (txn %0d): got %0d, expected %0d", name, n_txn, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit s, input bit w,
                              input bit c, input bit p);
        m_clear = 0;
        if (r) begin
            m_state = 0; m_level = 0; m_lives = 0; m_vic = 0; m_ticks = 0; m_go = 0;
        end else begin
            case (m_state)
                0: if (!s) begin
                    m_state = 1; m_level = 0; m_lives = LIVES_INIT; m_vic = 0; m_clear = 1;
                end
                1: if (!w) begin
                    if (m_level < LEVEL_MAX) begin m_level++; m_state = 2; end
                    else begin m_state = 4; m_vic = 1; end
                    m_ticks = 0; m_go = 0;
                end else if (!c) begin
                    m_lives--; m_state = 3; m_ticks = 0;
                end else if (PAUSE_EN && !p) begin
                    m_state = 5;
                end
                2, 3: if (m_ticks == HOLD_TICKS) begin
                    if (m_state == 2 || m_lives > 0) begin m_state = 1; m_clear = 1; end
                    else begin m_state = 4; m_vic = 0; m_go = 0; end
                end else if (t) begin
                    m_ticks++;
                end
                4: begin
                    if (m_go == 0) begin if (s) m_go = 1; end
                    else if (m_go == 1) begin if (!s) m_go = 2; end
                    else if (s) m_state = 0;
                end
                5: if (p) m_state = 1;
                default: m_state = 0;
            endcase
        end
        m_run = (m_state == 1) ? 1 : 0;
    endtask

    // One clock: drive inputs, step the model at the edge, compare just after it.
    task automatic apply(input bit r, input bit t, input bit s, input bit w,
                         input bit c, input bit p);
        @(negedge clk);
        rst = r; tick = t; start_n = s; win_n = w; coll_n = c; pause_n = p;
        @(posedge clk);
        model_step(r, t, s, w, c, p);
        #1;
        n_txn++;
        $display("txn %0d in r%0b t%0b s%0b w%0b c%0b p%0b -> state %0d level %0d lives %0d clear %0b run %0b vic %0b",
                 n_txn, r, t, s, w, c, p, state, level, lives, clear, run, victory);
        check("state", int'(state), m_state);
        check("level", int'(level), m_level);
        check("lives", int'(lives), m_lives);
        check("clear", int'(clear), m_clear);
        check("run", int'(run), m_run);
        check("victory", int'(victory), m_vic);
    endtask

    task automatic hold_then(input bit s);
        for (int i = 0; i < HOLD_TICKS; i++) apply(0, 1, 1, 1, 1, 1);
        apply(0, 0, s, 1, 1, 1);
    endtask

    initial begin
        // Directed table: start, level-up, win+collision, death, reset mid-hold
        add(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0, 3, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1, 0, 3, 0, 1, 0);
        add(0, 1, 1, 0, 1, 2, 1, 3, 0, 0, 0);
        for (int i = 0; i < HOLD_TICKS; i++) add(0, 1, 1, 1, 1, 2, 1, 3, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 1, 3, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 3, 0, 1, 0);
        add(0, 0, 1, 0, 0, 2, 2, 3, 0, 0, 0);
        for (int i = 0; i < HOLD_TICKS; i++) add(0, 1, 1, 1, 1, 2, 2, 3, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 2, 3, 1, 1, 0);
        add(0, 0, 1, 1, 0, 3, 2, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 1, 3, 2, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            apply(vecs[k].r, vecs[k].t, vecs[k].s, vecs[k].w, vecs[k].c, 1'b1);
            check("tbl_state", int'(state), vecs[k].st);
            check("tbl_level", int'(level), vecs[k].lv);
            check("tbl_lives", int'(lives), vecs[k].li);
            check("tbl_clear", int'(clear), vecs[k].cl);
            check("tbl_run", int'(run), vecs[k].ru);
            check("tbl_victory", int'(victory), vecs[k].vi);
        end

        // Three deaths, start held low into game over, then release/press/release
        apply(0, 0, 0, 1, 1, 1);
        for (int k = 0; k < LIVES_INIT; k++) begin
            apply(0, 0, 1, 1, 0, 1);
            check("death_lives", int'(lives), LIVES_INIT - 1 - k);
            hold_then((k == LIVES_INIT - 1) ? 1'b0 : 1'b1);
        end
        check("over_state", int'(state), 4);
        check("over_victory", int'(victory), 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 1, 1);
        check("over_held", int'(state), 4);
        apply(0, 0, 1, 1, 1, 1);
        apply(0, 0, 0, 1, 1, 1);
        check("over_pressed", int'(state), 4);
        apply(0, 0, 1, 1, 1, 1);
        check("over_to_idle", int'(state), 0);

        // Seven wins to the last level, eighth win ends the game as a victory
        apply(0, 0, 0, 1, 1, 1);
        for (int k = 0; k < LEVEL_MAX; k++) begin
            apply(0, 0, 1, 0, 1, 1);
            hold_then(1'b1);
        end
        check("max_level", int'(level), LEVEL_MAX);
        apply(0, 0, 1, 0, 1, 1);
        check("win_over_state", int'(state), 4);
        check("win_victory", int'(victory), 1);
        check("win_level_sat", int'(level), LEVEL_MAX);
        apply(0, 0, 1, 0, 0, 1);
        check("over_ignores_win", int'(state), 4);

`ifdef SC_GAMEFSM_PAUSE_EN
        apply(1, 0, 1, 1, 1, 1);
        apply(0, 0, 0, 1, 1, 1);
        apply(0, 1, 1, 1, 1, 0);
        check("pause_state", int'(state), 5);
        check("pause_run", int'(run), 0);
        apply(0, 0, 1, 1, 1, 1);
        check("unpause_state", int'(state), 1);
        check("unpause_clear", int'(clear), 0);
`endif

        // Randomized play against the model
        apply(1, 0, 1, 1, 1, 1);
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(99) == 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(5) != 0),
                  ($urandom_range(9) != 0),
                  ($urandom_range(9) != 0),
                  ($urandom_range(7) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
